// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: branch/NPC inputs, icache request/response and the decode-facing
// fetch queue head. Signal suffixes give the direction as seen by fetch_queue.
//   master : the fetch_queue side (drives fetch_* / icache request / pc_f outputs)
//   slave  : the environment (branch unit, NPC logic, icache, decode)
// LINE_W must match the LINE_W of the fetch_queue instance it connects to.
interface fetch_queue_if #(
    parameter int unsigned LINE_W = 128
) ();
    logic              branch_request_i;
    logic [31:0]       branch_pc_i;
    logic [1:0]        branch_priv_i;
    logic              fetch_invalidate_i;
    logic [31:0]       next_pc_f_i;
    logic [1:0]        next_taken_f_i;
    logic              icache_accept_i;
    logic              icache_valid_i;
    logic              icache_error_i;
    logic              icache_page_fault_i;
    logic [LINE_W-1:0] icache_inst_i;
    logic              fetch_accept_i;

    logic              fetch_valid_o;
    logic [LINE_W-1:0] fetch_instr_o;
    logic [31:0]       fetch_pc_o;
    logic [1:0]        fetch_pred_branch_o;
    logic              fetch_fault_fetch_o;
    logic              fetch_fault_page_o;
    logic              icache_rd_o;
    logic [31:0]       icache_pc_o;
    logic [1:0]        icache_priv_o;
    logic              icache_flush_o;
    logic [31:0]       pc_f_o;
    logic              pc_accept_o;

    modport master (
        input  branch_request_i, branch_pc_i, branch_priv_i, fetch_invalidate_i,
               next_pc_f_i, next_taken_f_i, icache_accept_i, icache_valid_i,
               icache_error_i, icache_page_fault_i, icache_inst_i, fetch_accept_i,
        output fetch_valid_o, fetch_instr_o, fetch_pc_o, fetch_pred_branch_o,
               fetch_fault_fetch_o, fetch_fault_page_o, icache_rd_o, icache_pc_o,
               icache_priv_o, icache_flush_o, pc_f_o, pc_accept_o
    );

    modport slave (
        output branch_request_i, branch_pc_i, branch_priv_i, fetch_invalidate_i,
               next_pc_f_i, next_taken_f_i, icache_accept_i, icache_valid_i,
               icache_error_i, icache_page_fault_i, icache_inst_i, fetch_accept_i,
        input  fetch_valid_o, fetch_instr_o, fetch_pc_o, fetch_pred_branch_o,
               fetch_fault_fetch_o, fetch_fault_page_o, icache_rd_o, icache_pc_o,
               icache_priv_o, icache_flush_o, pc_f_o, pc_accept_o
    );
endinterface

// File: rtl/fetch_queue.sv
// Front-end fetch unit between branch/NPC logic and the instruction cache.
// Keeps up to MAX_OUTSTANDING line requests in flight, queues returned lines in a
// FIFO_DEPTH-entry response queue ahead of decode, and drops responses belonging to
// requests issued before a redirect by means of a kill counter.
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset
//   bus    : fetch_queue_if.master -- branch/NPC inputs, icache request/response,
//            decode-facing queue head (fetch_*), current fetch PC (pc_f_o/pc_accept_o)
module fetch_queue #(
    parameter int unsigned LINE_W          = 128,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter bit          SUPPORT_MMU     = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fetch_queue_if.master bus
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned QW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [1:0]    PRIV_MACHINE = 2'b11;
    localparam logic [31:0]   ALIGN_MASK   = ~(32'(LINE_W / 8) - 32'd1);
    localparam logic [CW:0]   DEPTH_L      = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] MAXO_L       = CW'(MAX_OUTSTANDING);

    // Tag FIFO pointers wrap modulo MAX_OUTSTANDING, which need not be a power of 2.
    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
    endfunction

    // Control state
    logic              active_q, active_d;
    logic              flush_busy_q, flush_busy_d;
    logic [31:0]       pc_f_q, pc_f_d;
    logic [1:0]        priv_q, priv_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     kill_q, kill_d;

    // Tag FIFO: PC and prediction of each request in flight, in issue order
    logic [31:0]       tag_pc_q   [MAX_OUTSTANDING];
    logic [1:0]        tag_pred_q [MAX_OUTSTANDING];
    logic [TW-1:0]     tag_wr_q, tag_wr_d;
    logic [TW-1:0]     tag_rd_q, tag_rd_d;

    // Response queue
    logic [LINE_W-1:0] q_data_q [FIFO_DEPTH];
    logic [31:0]       q_pc_q   [FIFO_DEPTH];
    logic [1:0]        q_pred_q [FIFO_DEPTH];
    logic              q_err_q  [FIFO_DEPTH];
    logic              q_pf_q   [FIFO_DEPTH];
    logic [QW-1:0]     q_wr_q, q_wr_d;
    logic [QW-1:0]     q_rd_q, q_rd_d;
    logic [CW-1:0]     q_count_q, q_count_d;

    logic              flush_busy;
    logic [CW:0]       in_use;
    logic              rd;
    logic              issue;
    logic              resp;
    logic              kill_resp;
    logic              push;
    logic              pop;
    logic              fetch_valid;

    always_comb begin
        flush_busy  = bus.fetch_invalidate_i | flush_busy_q;
        // Queue slots already spoken for: lines held plus lines still to arrive.
        in_use      = {1'b0, q_count_q} + {1'b0, outst_q};
        // A redirect cycle never issues, so the target is the first PC requested after it.
        rd          = active_q & ~flush_busy & ~bus.branch_request_i &
                      (outst_q < MAXO_L) & (in_use < DEPTH_L);
        issue       = rd & bus.icache_accept_i;
        // Responses with nothing outstanding (e.g. straggling across a reset) are ignored.
        resp        = bus.icache_valid_i & (outst_q != '0);
        kill_resp   = resp & (kill_q != '0);
        push        = resp & ~kill_resp & ~bus.branch_request_i;
        fetch_valid = (q_count_q != '0);
        pop         = fetch_valid & bus.fetch_accept_i;
    end

    always_comb begin
        active_d  = active_q | bus.branch_request_i;
        pc_f_d    = pc_f_q;
        priv_d    = priv_q;
        outst_d   = outst_q;
        kill_d    = kill_q;
        tag_wr_d  = tag_wr_q;
        tag_rd_d  = tag_rd_q;
        q_wr_d    = q_wr_q;
        q_rd_d    = q_rd_q;
        q_count_d = q_count_q;

        if (issue) begin
            outst_d  = outst_d + CW'(1);
            tag_wr_d = tag_inc(tag_wr_q);
            pc_f_d   = bus.next_pc_f_i;
        end
        if (resp) begin
            outst_d  = outst_d - CW'(1);
            tag_rd_d = tag_inc(tag_rd_q);
            if (kill_resp) begin
                kill_d = kill_q - CW'(1);
            end
        end
        if (pop) begin
            q_rd_d    = q_rd_q + QW'(1);
            q_count_d = q_count_d - CW'(1);
        end
        if (push) begin
            q_wr_d    = q_wr_q + QW'(1);
            q_count_d = q_count_d + CW'(1);
        end
        if (bus.branch_request_i) begin
            q_wr_d    = '0;
            q_rd_d    = '0;
            q_count_d = '0;
            // Everything still in flight after this edge belongs to the old path.
            kill_d    = outst_d;
            pc_f_d    = bus.branch_pc_i;
            if (SUPPORT_MMU) begin
                priv_d = bus.branch_priv_i;
            end
        end

        flush_busy_d = flush_busy & (outst_d != '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active_q     <= 1'b0;
            flush_busy_q <= 1'b0;
            pc_f_q       <= '0;
            priv_q       <= PRIV_MACHINE;
            outst_q      <= '0;
            kill_q       <= '0;
            tag_wr_q     <= '0;
            tag_rd_q     <= '0;
            q_wr_q       <= '0;
            q_rd_q       <= '0;
            q_count_q    <= '0;
        end else begin
            active_q     <= active_d;
            flush_busy_q <= flush_busy_d;
            pc_f_q       <= pc_f_d;
            priv_q       <= priv_d;
            outst_q      <= outst_d;
            kill_q       <= kill_d;
            tag_wr_q     <= tag_wr_d;
            tag_rd_q     <= tag_rd_d;
            q_wr_q       <= q_wr_d;
            q_rd_q       <= q_rd_d;
            q_count_q    <= q_count_d;
        end
    end

    // Storage arrays need no reset: they are only observed through the valid count.
    always_ff @(posedge clk_i) begin
        if (issue) begin
            tag_pc_q[tag_wr_q]   <= pc_f_q & ALIGN_MASK;
            tag_pred_q[tag_wr_q] <= bus.next_taken_f_i;
        end
        if (push) begin
            q_data_q[q_wr_q] <= bus.icache_inst_i;
            q_pc_q[q_wr_q]   <= tag_pc_q[tag_rd_q];
            q_pred_q[q_wr_q] <= tag_pred_q[tag_rd_q];
            q_err_q[q_wr_q]  <= bus.icache_error_i;
            q_pf_q[q_wr_q]   <= bus.icache_page_fault_i;
        end
    end

    always_comb begin
        bus.fetch_valid_o       = fetch_valid;
        bus.fetch_instr_o       = '0;
        bus.fetch_pc_o          = '0;
        bus.fetch_pred_branch_o = '0;
        bus.fetch_fault_fetch_o = 1'b0;
        bus.fetch_fault_page_o  = 1'b0;
        if (fetch_valid) begin
            bus.fetch_instr_o       = q_data_q[q_rd_q];
            bus.fetch_pc_o          = q_pc_q[q_rd_q];
            bus.fetch_pred_branch_o = q_pred_q[q_rd_q];
            bus.fetch_fault_fetch_o = q_err_q[q_rd_q];
            bus.fetch_fault_page_o  = q_pf_q[q_rd_q];
        end
        bus.icache_rd_o    = rd;
        bus.icache_pc_o    = pc_f_q & ALIGN_MASK;
        bus.icache_priv_o  = priv_q;
        bus.icache_flush_o = bus.fetch_invalidate_i;
        bus.pc_f_o         = pc_f_q;
        bus.pc_accept_o    = issue;
    end

endmodule
